rgb_pwm_fader: RTL

Three-channel PWM generator with linear fade, placed directly upstream of the SB_RGBA_DRV RGB LED driver. Its pwm outputs connect to RGB0PWM/RGB1PWM/RGB2PWM. It takes per-channel 8-bit brightness targets from control logic. Optionally it ramps each channel toward its target one step at a time, so colour changes are smooth instead of stepped.

---
 rtl/rgb_pwm_fader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//   Three-channel PWM generator with optional linear fade. It sits directly
//   upstream of the SB_RGBA_DRV RGB LED driver: pwm[0..2] feed RGB0PWM,
//   RGB1PWM and RGB2PWM.
//
// Parameters
//   PWM_BITS  duty / counter width; one PWM period is 2^PWM_BITS clocks
//   FADE_DIV  one fade tick every FADE_DIV+1 PWM periods
//
// Ports
//   clk          system clock (LF oscillator or any fabric clock)
//   rst_n        asynchronous active-low reset
//   tgt_r/g/b    target duty per channel
//   tgt_load     single-cycle strobe, captures all three targets
//   fade_en      1 = ramp toward target, 0 = jump to target
//   pwm          registered PWM outputs, [0]=R [1]=G [2]=B
//   busy         high while a fade is in progress
//   period_strb  one-cycle pulse on the first clock of each PWM period
//
// Build option
//   RGB_PWM_FADER_GAMMA_EN  when defined, the applied duty is (cur*cur)>>PWM_BITS
//                           instead of cur.

module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] tgt_r,
    input  logic [PWM_BITS-1:0] tgt_g,
    input  logic [PWM_BITS-1:0] tgt_b,
    input  logic                tgt_load,
    input  logic                fade_en,
    output logic [2:0]          pwm,
    output logic                busy,
    output logic                period_strb
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam int                  DIV_W   = (FADE_DIV > 0) ? $clog2(FADE_DIV + 1) : 1;
    localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'(FADE_DIV);

    typedef enum logic {IDLE, FADE} state_t;

    state_t                     state;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic [DIV_W-1:0]           div_cnt;
    logic [2:0][PWM_BITS-1:0]   tgt;
    logic [2:0][PWM_BITS-1:0]   cur;
    logic [2:0][PWM_BITS-1:0]   act;
    logic [2:0][PWM_BITS-1:0]   tgt_in;
    logic [2:0][PWM_BITS-1:0]   tgt_nxt;
    logic [2:0][PWM_BITS-1:0]   cur_step;
    logic                       fade_tick;
    logic                       all_eq;

    // Mapping from ramp value to applied duty.
    function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] c);
`ifdef RGB_PWM_FADER_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, c};
        return PWM_BITS'(sq >> PWM_BITS);
`else
        return c;
`endif
    endfunction

    // One LSB toward the target, or hold if already there.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                        input logic [PWM_BITS-1:0] t);
        if (c < t)
            return c + 1'b1;
        else if (c > t)
            return c - 1'b1;
        else
            return c;
    endfunction

    always_comb begin
        tgt_in    = {tgt_b, tgt_g, tgt_r};
        tgt_nxt   = tgt_load ? tgt_in : tgt;
        // period_strb is high exactly while pwm_cnt == 0, so it doubles as
        // the divider's period event.
        fade_tick = (state == FADE) && period_strb && (div_cnt == DIV_MAX);
        cur_step  = cur;
        for (int i = 0; i < 3; i++) begin
            if (fade_tick)
                cur_step[i] = step_toward(cur[i], tgt[i]);
        end
        // Compare against the targets as they will be after this edge so a
        // retarget onto the current value also terminates the fade.
        all_eq = (cur_step == tgt_nxt);
    end

    // PWM counter, applied duty and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            period_strb <= 1'b0;
            pwm         <= 3'b000;
            act         <= '0;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            period_strb <= (pwm_cnt == CNT_MAX);
            for (int i = 0; i < 3; i++) begin
                pwm[i] <= (pwm_cnt < act[i]);
                // Reload only on the last count so a period never mixes duties.
                if (pwm_cnt == CNT_MAX)
                    act[i] <= duty_map(cur[i]);
            end
        end
    end

    // Target capture and fade control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
            tgt     <= '0;
            cur     <= '0;
        end else begin
            tgt <= tgt_nxt;
            case (state)
                IDLE: begin
                    if (tgt_load) begin
                        if (fade_en) begin
                            state   <= FADE;
                            busy    <= 1'b1;
                            div_cnt <= '0;
                        end else begin
                            cur <= tgt_in;
                        end
                    end
                end
                FADE: begin
                    if (!fade_en) begin
                        cur   <= tgt_nxt;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cur <= cur_step;
                        if (period_strb)
                            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
                        if (all_eq) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
